fetch_redirect_unit: RTL and testbench

//  Fetch-side next-PC generator and branch bookkeeping, sitting directly upstream of the 2-bit branch predictor.

---
 rtl/branch_pkg.sv | 18 +
 rtl/branch_fifo.sv | 54 +++++
 rtl/fetch_redirect_unit.sv | 146 ++++++++++++++
 tb/tb_fetch_redirect_unit.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/branch_pkg.sv
// Shared opcodes, branch decode and the pending-branch queue entry layout.
package branch_pkg;

    localparam logic [5:0] BAL_OP = 6'b000001;
    localparam logic [3:0] BS_OP  = 4'b0001;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        pred;
        logic [31:0] tgt;
    } br_entry_t;

    function automatic logic is_branch(input logic [31:0] inst);
        return (inst[31:26] == BAL_OP) || (inst[31:28] == BS_OP);
    endfunction

endpackage

// File: rtl/branch_fifo.sv
// Circular queue of pending branches; head visible combinationally, push/pop take effect at the edge.
// Latency 1 cycle push-to-head; no internal backpressure, caller must not push when full without a pop.
module branch_fifo
    import branch_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      push_i,
    input  logic      pop_i,
    input  logic      clear_i,
    input  br_entry_t push_dat_i,
    output br_entry_t head_o,
    output logic      full_o,
    output logic      empty_o
);

    br_entry_t        mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W:0]   cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else if (clear_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push_i) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop_i)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            case ({push_i, pop_i})
                2'b10:   cnt_q <= cnt_q + (PTR_W+1)'(1);
                2'b01:   cnt_q <= cnt_q - (PTR_W+1)'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    // Storage needs no reset: an entry is only read once the count says it was written.
    always_ff @(posedge clk) begin
        if (push_i && !clear_i) mem_q[wr_ptr_q] <= push_dat_i;
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign full_o  = (cnt_q == (PTR_W+1)'(DEPTH));
    assign empty_o = (cnt_q == '0);

endmodule

// File: rtl/fetch_redirect_unit.sv
// Next-PC generation, pending-branch tracking, mispredict redirect/flush and predictor update tuple.
// Redirect and update outputs appear 1 cycle after resolution; fetch_stall holds the PC when the queue is full.
// Optional BRANCH_STAT_EN builds saturating resolved/mispredict counters, otherwise they read 0.
module fetch_redirect_unit
    import branch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0001_0000,
    parameter int          DEPTH    = 4,
    parameter int          PTR_W    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    output logic [31:0] Iadd,
    input  logic        inst_valid,
    input  logic [31:0] Idata,
    input  logic        predict,
    input  logic [31:0] pred_target,
    input  logic        res_valid,
    input  logic        res_taken,
    input  logic [31:0] res_target,
    output logic        fetch_stall,
    output logic        flush,
    output logic        upd_valid,
    output logic [31:0] Badd,
    output logic [31:0] Bdata,
    output logic        result,
    output logic        q_err,
    output logic [31:0] stat_br,
    output logic [31:0] stat_miss
);

    logic [31:0] pc_q, pc_d;
    logic        flush_q;
    logic        upd_valid_q;
    logic [31:0] badd_q;
    logic [31:0] bdata_q;
    logic        result_q;
    logic        q_err_q;

    logic        br_fetch;
    logic        push;
    logic        pop;
    logic        mispredict;
    logic        q_full;
    logic        q_empty;
    br_entry_t   push_ent;
    br_entry_t   head;

    assign br_fetch = inst_valid && is_branch(Idata);
    assign pop      = res_valid && !q_empty;

    // A wrong target on a correctly-predicted taken branch is still a mispredict.
    assign mispredict = pop && ((res_taken != head.pred) ||
                                (res_taken && head.pred && (res_target != head.tgt)));

    assign fetch_stall = q_full && br_fetch && !res_valid;
    assign push        = !stall && br_fetch && (!q_full || pop);

    always_comb begin
        push_ent      = '0;
        push_ent.pc   = pc_q;
        push_ent.inst = Idata;
        push_ent.pred = predict;
        push_ent.tgt  = predict ? pred_target : pc_q + 32'd4;
    end

    always_comb begin
        pc_d = pc_q + 32'd4;
        if (mispredict)
            pc_d = res_taken ? res_target : head.pc + 32'd4;
        else if (stall || fetch_stall)
            pc_d = pc_q;
        else if (br_fetch && predict)
            pc_d = pred_target;
    end

    branch_fifo #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push_i     (push),
        .pop_i      (pop),
        .clear_i    (mispredict),
        .push_dat_i (push_ent),
        .head_o     (head),
        .full_o     (q_full),
        .empty_o    (q_empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q        <= RESET_PC;
            flush_q     <= 1'b0;
            upd_valid_q <= 1'b0;
            badd_q      <= '0;
            bdata_q     <= '0;
            result_q    <= 1'b0;
            q_err_q     <= 1'b0;
        end else begin
            pc_q        <= pc_d;
            flush_q     <= mispredict;
            upd_valid_q <= pop;
            q_err_q     <= q_err_q || (res_valid && q_empty);
            if (pop) begin
                badd_q   <= head.pc;
                bdata_q  <= head.inst;
                result_q <= res_taken;
            end
        end
    end

`ifdef BRANCH_STAT_EN
    logic [31:0] stat_br_q;
    logic [31:0] stat_miss_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_br_q   <= '0;
            stat_miss_q <= '0;
        end else begin
            if (pop && (stat_br_q != 32'hFFFF_FFFF))
                stat_br_q <= stat_br_q + 32'd1;
            if (mispredict && (stat_miss_q != 32'hFFFF_FFFF))
                stat_miss_q <= stat_miss_q + 32'd1;
        end
    end

    assign stat_br   = stat_br_q;
    assign stat_miss = stat_miss_q;
`else
    assign stat_br   = '0;
    assign stat_miss = '0;
`endif

    assign Iadd      = pc_q;
    assign flush     = flush_q;
    assign upd_valid = upd_valid_q;
    assign Badd      = badd_q;
    assign Bdata     = bdata_q;
    assign result    = result_q;
    assign q_err     = q_err_q;

endmodule

// File: tb/tb_fetch_redirect_unit.sv
// Directed bench for fetch_redirect_unit: hand-computed PC flow, redirects, queue-full and reset cases.
module tb_fetch_redirect_unit;

    localparam logic [31:0] NOP = 32'h0000_0000;
    localparam logic [31:0] BAL = 32'h0400_0000;
    localparam logic [31:0] BS  = 32'h1000_0000;
`ifdef BRANCH_STAT_EN
    localparam logic [31:0] EXP_BR   = 32'd5;
    localparam logic [31:0] EXP_MISS = 32'd3;
`else
    localparam logic [31:0] EXP_BR   = 32'd0;
    localparam logic [31:0] EXP_MISS = 32'd0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic [31:0] Iadd;
    logic        inst_valid;
    logic [31:0] Idata;
    logic        predict;
    logic [31:0] pred_target;
    logic        res_valid;
    logic        res_taken;
    logic [31:0] res_target;
    logic        fetch_stall;
    logic        flush;
    logic        upd_valid;
    logic [31:0] Badd;
    logic [31:0] Bdata;
    logic        result;
    logic        q_err;
    logic [31:0] stat_br;
    logic [31:0] stat_miss;

    int n_cmp  = 0;
    int n_fail = 0;

    fetch_redirect_unit dut (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .Iadd        (Iadd),
        .inst_valid  (inst_valid),
        .Idata       (Idata),
        .predict     (predict),
        .pred_target (pred_target),
        .res_valid   (res_valid),
        .res_taken   (res_taken),
        .res_target  (res_target),
        .fetch_stall (fetch_stall),
        .flush       (flush),
        .upd_valid   (upd_valid),
        .Badd        (Badd),
        .Bdata       (Bdata),
        .result      (result),
        .q_err       (q_err),
        .stat_br     (stat_br),
        .stat_miss   (stat_miss)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish before 200000");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input logic [31:0] inst, input logic pr, input logic [31:0] tgt);
        inst_valid  = 1'b1;
        Idata       = inst;
        predict     = pr;
        pred_target = tgt;
    endtask

    task automatic resolve(input logic v, input logic tk, input logic [31:0] tgt);
        res_valid  = v;
        res_taken  = tk;
        res_target = tgt;
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0;
        fetch(NOP, 1'b0, 32'h0);
        resolve(1'b0, 1'b0, 32'h0);
        #2;
        chk("rst_iadd", Iadd, 32'h0001_0000);
        chk("rst_flush", {31'b0, flush}, 32'd0);
        chk("rst_upd", {31'b0, upd_valid}, 32'd0);
        chk("rst_qerr", {31'b0, q_err}, 32'd0);
        chk("rst_fstall", {31'b0, fetch_stall}, 32'd0);
        chk("rst_badd", Badd, 32'd0);
        chk("rst_bdata", Bdata, 32'd0);
        chk("rst_result", {31'b0, result}, 32'd0);
        chk("rst_stat_br", stat_br, 32'd0);
        rst = 1'b0;

        // straight-line sequential fetch
        tick(); chk("seq_1", Iadd, 32'h0001_0004);
        tick(); chk("seq_2", Iadd, 32'h0001_0008);
        tick(); chk("seq_3", Iadd, 32'h0001_000C);
        chk("seq_flush", {31'b0, flush}, 32'd0);

        // async reset between edges
        #1; rst = 1'b1; #1;
        chk("arst_iadd", Iadd, 32'h0001_0000);
        rst = 1'b0;

        tick(); chk("nop_iadd", Iadd, 32'h0001_0004);
        fetch(BAL, 1'b1, 32'h0001_0040);
        tick(); chk("bal_pred_iadd", Iadd, 32'h0001_0040);

        // correct resolution of bal while bs (predicted not taken) is pushed
        fetch(BS, 1'b0, 32'h1234_5678);
        resolve(1'b1, 1'b1, 32'h0001_0040);
        tick();
        chk("bs_iadd", Iadd, 32'h0001_0044);
        chk("bal_flush", {31'b0, flush}, 32'd0);
        chk("bal_upd", {31'b0, upd_valid}, 32'd1);
        chk("bal_badd", Badd, 32'h0001_0004);
        chk("bal_bdata", Bdata, BAL);
        chk("bal_result", {31'b0, result}, 32'd1);

        // bs actually taken: direction mispredict
        fetch(NOP, 1'b0, 32'h0);
        resolve(1'b1, 1'b1, 32'h0001_0080);
        tick();
        chk("bs_flush", {31'b0, flush}, 32'd1);
        chk("bs_redirect", Iadd, 32'h0001_0080);
        chk("bs_badd", Badd, 32'h0001_0040);
        chk("bs_bdata", Bdata, BS);

        resolve(1'b0, 1'b0, 32'h0);
        tick();
        chk("post_flush", {31'b0, flush}, 32'd0);
        chk("post_upd", {31'b0, upd_valid}, 32'd0);
        chk("badd_hold", Badd, 32'h0001_0040);
        chk("post_iadd", Iadd, 32'h0001_0084);

        // taken-predicted branch, resolved taken to a different target
        fetch(BAL, 1'b1, 32'h0001_0100);
        tick(); chk("tgt_pred_iadd", Iadd, 32'h0001_0100);
        fetch(NOP, 1'b0, 32'h0);
        resolve(1'b1, 1'b1, 32'h0001_0200);
        tick();
        chk("tgt_flush", {31'b0, flush}, 32'd1);
        chk("tgt_redirect", Iadd, 32'h0001_0200);

        // queue was cleared: resolution now hits an empty queue
        resolve(1'b1, 1'b0, 32'h0);
        tick();
        chk("empty_qerr", {31'b0, q_err}, 32'd1);
        chk("empty_upd", {31'b0, upd_valid}, 32'd0);
        chk("empty_flush", {31'b0, flush}, 32'd0);
        chk("empty_iadd", Iadd, 32'h0001_0204);

        // fill the queue with four not-taken-predicted branches
        resolve(1'b0, 1'b0, 32'h0);
        fetch(BAL, 1'b0, 32'h0);
        for (int i = 0; i < 4; i++) tick();
        chk("fill_iadd", Iadd, 32'h0001_0214);
        chk("fill_fstall", {31'b0, fetch_stall}, 32'd1);
        tick();
        chk("full_hold", Iadd, 32'h0001_0214);
        chk("full_fstall", {31'b0, fetch_stall}, 32'd1);

        // resolution in the same cycle frees the slot
        resolve(1'b1, 1'b0, 32'h0);
        #1;
        chk("pushpop_fstall", {31'b0, fetch_stall}, 32'd0);
        tick();
        chk("pushpop_iadd", Iadd, 32'h0001_0218);
        chk("pushpop_upd", {31'b0, upd_valid}, 32'd1);
        chk("pushpop_badd", Badd, 32'h0001_0204);
        chk("pushpop_result", {31'b0, result}, 32'd0);
        chk("pushpop_flush", {31'b0, flush}, 32'd0);

        // downstream stall holds the PC
        fetch(NOP, 1'b0, 32'h0);
        resolve(1'b0, 1'b0, 32'h0);
        stall = 1'b1;
        tick();
        chk("stall_hold", Iadd, 32'h0001_0218);

        // redirect wins over stall
        resolve(1'b1, 1'b1, 32'h0001_0300);
        tick();
        chk("stall_redirect", Iadd, 32'h0001_0300);
        chk("stall_flush", {31'b0, flush}, 32'd1);
        chk("stall_badd", Badd, 32'h0001_0208);
        chk("stat_br", stat_br, EXP_BR);
        chk("stat_miss", stat_miss, EXP_MISS);

        // async reset with branches pending
        stall = 1'b0;
        resolve(1'b0, 1'b0, 32'h0);
        fetch(BS, 1'b0, 32'h0);
        tick();
        chk("pend_iadd", Iadd, 32'h0001_0304);
        #1; rst = 1'b1; #1;
        chk("midrst_iadd", Iadd, 32'h0001_0000);
        chk("midrst_qerr", {31'b0, q_err}, 32'd0);
        chk("midrst_flush", {31'b0, flush}, 32'd0);
        chk("midrst_badd", Badd, 32'd0);
        chk("midrst_stat", stat_br, 32'd0);
        rst = 1'b0;
        fetch(NOP, 1'b0, 32'h0);
        resolve(1'b1, 1'b0, 32'h0);
        tick();
        chk("midrst_empty_qerr", {31'b0, q_err}, 32'd1);
        chk("midrst_empty_upd", {31'b0, upd_valid}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
